// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - load/schedule-word bus between a SHA-256 message source, the scheduler and its consumer
interface sha256_msg_schedule_if;
    logic        start;
    logic        load_valid;
    logic [31:0] load_word;
    logic        load_ready;
    logic        w_valid;
    logic [31:0] w_data;
    logic [5:0]  w_index;
    logic        w_ready;
    logic        busy;
    logic        done;

    modport slave (
        input  start, load_valid, load_word, w_ready,
        output load_ready, w_valid, w_data, w_index, busy, done
    );

    modport master (
        output start, load_valid, load_word, w_ready,
        input  load_ready, w_valid, w_data, w_index, busy, done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule W[0..63] from one 16-word block, 16-entry rolling buffer
module sha256_msg_schedule (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_schedule_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  t_q, t_d;
    logic        done_q, done_d;
    logic [31:0] buf_q [16];

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic        expanding;
    logic        load_fire;
    logic        w_fire;
    logic [3:0]  slot;
    logic [3:0]  idx_m2, idx_m7, idx_m15;
    logic [31:0] w_calc;
    logic [31:0] w_word;

    // The buffer holds W[t-16..t-1]; 4-bit slot arithmetic gives the circular wrap for free.
    assign slot      = t_q[3:0];
    assign idx_m2    = slot + 4'd14;
    assign idx_m7    = slot + 4'd9;
    assign idx_m15   = slot + 4'd1;
    assign w_calc    = sigma1(buf_q[idx_m2]) + buf_q[idx_m7] + sigma0(buf_q[idx_m15]) + buf_q[slot];
    assign w_word    = (t_q < 6'd16) ? buf_q[slot] : w_calc;

    assign expanding = (state_q == S_EXPAND);
    assign load_fire = (state_q == S_LOAD) && bus.load_valid;
    assign w_fire    = expanding && bus.w_ready;

    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.w_valid    = expanding;
    assign bus.w_data     = expanding ? w_word : 32'd0;
    assign bus.w_index    = expanding ? t_q : 6'd0;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                end
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_EXPAND;
                        t_d     = 6'd0;
                    end
                end
            end
            S_EXPAND: begin
                if (bus.w_ready) begin
                    if (t_q == 6'd63) begin
                        state_d = S_IDLE;
                        t_d     = 6'd0;
                        done_d  = 1'b1;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            t_q     <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    // Buffer is data-only storage; reset leaves it untouched since every block reloads all 16 slots.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_q[cnt_q] <= bus.load_word;
        end else if (w_fire && (t_q[5:4] != 2'b00)) begin
            buf_q[slot] <= w_word;
        end
    end
endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a new block; honoured only in IDLE.
REQ-005 load_valid  input  1  load_word carries a message word.
REQ-006 load_word  input  32  message word M[i], i=0..15, big-endian word order.
REQ-007 load_ready  output  1  block accepts a load word this cycle.
REQ-008 w_valid  output  1  w_data/w_index hold schedule word W[t].
REQ-009 w_data  output  32  schedule word W[t].
REQ-010 w_index  output  6  t, 0..63.
REQ-011 w_ready  input  1  consumer accepts W[t] this cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-014 The state machine SHALL have states IDLE, LOAD, EXPAND; the state register and all storage SHALL update only on rising clk.
REQ-015 IDLE: start=1 -> LOAD with load counter=0; start in LOAD or EXPAND SHALL be ignored.
REQ-016 LOAD: load_ready=1; each load_valid&load_ready writes load_word into buf[cnt] (16x32 circular buffer) and increments cnt; load_valid outside LOAD SHALL be ignored.
REQ-017 When the 16th word is accepted, the next state SHALL be EXPAND with t=0; W[0] SHALL be valid on the cycle after that acceptance (one-cycle latency).
REQ-018 EXPAND: w_valid=1, w_index=t; for t<16, w_data=buf[t]; for t>=16, w_data=sigma1(buf[(t+14)&15]) + buf[(t+9)&15] + sigma0(buf[(t+1)&15]) + buf[t&15], sum modulo 2^32.
REQ-019 sigma0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); sigma1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
REQ-020 On w_valid&w_ready with t>=16, w_data SHALL be written into buf[t&15]; t SHALL increment by 1 on every handshake.
REQ-021 While w_valid=1 and w_ready=0, w_data and w_index SHALL stay constant; no buffer write SHALL occur.
REQ-022 Handshake at t=63 SHALL return to IDLE and assert done for exactly the next cycle; t SHALL NOT wrap to 0 within a block.
REQ-023 w_data SHALL be 0 and w_index SHALL be 0 whenever w_valid=0.
REQ-024 w_ready is a don't-care outside EXPAND; throughput SHALL be one word per cycle with w_ready held high.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, load_ready=0, w_valid=0, w_data=0, w_index=0, busy=0, done=0, counters=0; buffer contents need not be cleared.
REQ-026 rst asserted mid-LOAD or mid-EXPAND SHALL abort the block with no done pulse; the next start after rst deassertion SHALL run a complete block normally.

Verification
REQ-027 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W[16]=0x61626380, W[17]=0x000F0000, 64 consecutive valid cycles, done pulses once.
REQ-028 Block W0=0x00000001, rest 0 -> W[16]=0x00000001, W[17]=0x00000000, W[18]=0x0000A000.
REQ-029 All-zero block -> all 64 words 0x00000000, w_index 0..63 in order, no gaps.
REQ-030 "abc" block, w_ready low 5 cycles at t=17 -> w_data held 0x000F0000, w_index held 17; remaining words identical to REQ-027.
REQ-031 load_valid gaps (1 word every 3 cycles) and start pulses during LOAD/EXPAND -> results identical to gap-free run, start ignored.
REQ-032 rst asserted at t=30 -> all outputs 0 on the same cycle, no done; restart with "abc" block reproduces REQ-027 values.
